ipml_fifo_wr_packer: RTL
========================

IPML_FIFO_WR_PACKER -- requirements
Module: ipml_fifo_wr_packer

Interface
REQ-001 SHALL have parameter c_IN_WIDTH, default 8: width of one input sample (legal 1..64).
REQ-002 SHALL have parameter c_PACK_RATIO, default 4: samples per FIFO word (legal 2..16); derived c_OUT_WIDTH = c_IN_WIDTH*c_PACK_RATIO.
REQ-003 SHALL have port wr_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port wr_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port din  input  c_IN_WIDTH  input sample.
REQ-006 SHALL have port din_vld  input  1  sample valid.
REQ-007 SHALL have port din_last  input  1  qualifies din as last sample of a frame; flushes partial word.
REQ-008 SHALL have port din_rdy  output  1  sample accepted when din_vld & din_rdy.
REQ-009 SHALL have port fifo_wr_data  output  c_OUT_WIDTH  packed word to FIFO write port.
REQ-010 SHALL have port fifo_wr_en  output  1  word valid toward FIFO.
REQ-011 SHALL have port fifo_wr_vld  input  1  FIFO not full (write ready).
REQ-012 SHALL have port stall_cnt  output  16  saturating count of stalled input cycles (see Configuration).

Function
REQ-013 SHALL pack little-endian: k-th accepted sample of a word (k = 0..c_PACK_RATIO-1) into bits [k*c_IN_WIDTH +: c_IN_WIDTH].
REQ-014 SHALL track fill with counter cnt (0..c_PACK_RATIO-1); states: EMPTY (cnt=0), FILL (cnt>0); output register state HOLD (out_full=1) or FREE.
REQ-015 SHALL complete a word when the accepted sample has cnt=c_PACK_RATIO-1 or din_last=1; cnt returns to 0 (EMPTY) on that edge.
REQ-016 SHALL zero-fill unused upper sample slots of a word completed by din_last.
REQ-017 SHALL load a completed word into the output register on the accepting edge; fifo_wr_en asserts the next cycle (latency 1 cycle from completing accept).
REQ-018 SHALL drive fifo_wr_en = out_full; word transfers on edge where fifo_wr_en & fifo_wr_vld, then out_full clears unless a new word completes on the same edge.
REQ-019 SHALL hold fifo_wr_data stable while fifo_wr_en=1 and fifo_wr_vld=0.
REQ-020 SHALL drive din_rdy = ~out_full | fifo_wr_vld (combinational); sustained throughput one sample per cycle when fifo_wr_vld=1.
REQ-021 SHALL, on simultaneous transfer and word completion, replace the output word with the new word, fifo_wr_en remaining 1, no loss or duplication.
REQ-022 SHALL ignore din and din_last when din_vld=0 or din_rdy=0.
REQ-023 SHALL treat din_last on the first sample (cnt=0) as a one-sample word.

Reset
REQ-024 SHALL on wr_rst=1 immediately clear cnt, out_full, pack and output registers, stall_cnt; fifo_wr_en=0, fifo_wr_data=0, din_rdy=1.
REQ-025 SHALL discard any partial word and any pending untransferred word on reset mid-operation; first word after release starts at slot 0.

Configuration
REQ-026 SHALL use macro IPML_PACK_STALL_CNT_EN.
REQ-027 With IPML_PACK_STALL_CNT_EN defined, stall_cnt SHALL increment each cycle din_vld=1 & din_rdy=0, saturating at 16'hFFFF, cleared only by reset.
REQ-028 Without it, stall_cnt SHALL be constant 0 and no counter logic synthesized; all other behaviour identical.

Verification (c_IN_WIDTH=8, c_PACK_RATIO=4)
REQ-029 Samples 01,02,03,04 back-to-back, fifo_wr_vld=1 -> one cycle after 04 accepted, fifo_wr_en=1, fifo_wr_data=32'h04030201 for one cycle.
REQ-030 Samples AA,BB with din_last on BB -> fifo_wr_data=32'h0000BBAA; next word starts at slot 0.
REQ-031 Word pending, fifo_wr_vld=0 for 5 cycles, din_vld=1 -> din_rdy=0, fifo_wr_data held, stall_cnt=5 (macro on) / 0 (macro off).
REQ-032 Continuous 16 samples 00..0F, fifo_wr_vld=1 -> 4 words 03020100..0F0E0D0C on 4 consecutive-completion cycles, no stall.
REQ-033 wr_rst asserted after 2 samples and with a pending word -> fifo_wr_en drops at once; after release 11,22,33,44 -> 32'h44332211 only.

Source files
------------

// File: rtl/ipml_fifo_wr_packer.sv
// Packs c_PACK_RATIO narrow samples, little-endian, into one FIFO word behind a one-word output register.
// Optional stalled-input counter enabled by defining IPML_PACK_STALL_CNT_EN.
module ipml_fifo_wr_packer #(
    parameter  int c_IN_WIDTH   = 8,
    parameter  int c_PACK_RATIO = 4,
    localparam int c_OUT_WIDTH  = c_IN_WIDTH * c_PACK_RATIO
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    input  logic [c_IN_WIDTH-1:0]  din,
    input  logic                   din_vld,
    input  logic                   din_last,
    output logic                   din_rdy,
    output logic [c_OUT_WIDTH-1:0] fifo_wr_data,
    output logic                   fifo_wr_en,
    input  logic                   fifo_wr_vld,
    output logic [15:0]            stall_cnt
);

    localparam int                   c_CNT_W    = $clog2(c_PACK_RATIO);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(c_PACK_RATIO - 1);

    typedef enum logic {
        FREE = 1'b0,
        HOLD = 1'b1
    } out_state_e;

    out_state_e             out_state_q, out_state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [c_OUT_WIDTH-1:0] pack_q, pack_d;
    logic [c_OUT_WIDTH-1:0] out_q, out_d;
    logic [c_OUT_WIDTH-1:0] word_comb;
    logic                   out_full;
    logic                   accept;
    logic                   complete;

    assign out_full     = (out_state_q == HOLD);
    assign din_rdy      = ~out_full | fifo_wr_vld;
    assign accept       = din_vld & din_rdy;
    assign complete     = accept & (din_last | (cnt_q == c_CNT_LAST));
    assign fifo_wr_en   = out_full;
    assign fifo_wr_data = out_q;

    // Upper slots come out zero because pack_q is cleared on every completion.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        word_comb = pack_q;
        for (int k = 0; k < c_PACK_RATIO; k++) begin
            if (cnt_q == c_CNT_W'(k)) begin
                word_comb[k*c_IN_WIDTH +: c_IN_WIDTH] = din;
            end
        end
    end

    always_comb begin
        pack_d = pack_q;
        cnt_d  = cnt_q;
        if (accept) begin
            if (complete) begin
                pack_d = '0;
                cnt_d  = '0;
            end else begin
                pack_d = word_comb;
                cnt_d  = cnt_q + c_CNT_W'(1);
            end
        end
    end

    // A completing word takes priority over a transfer, so a word that leaves
    // on the same edge is replaced in place and fifo_wr_en stays high.
    always_comb begin
        out_state_d = out_state_q;
        out_d       = out_q;
        if (complete) begin
            out_state_d = HOLD;
            out_d       = word_comb;
        end else if (out_full && fifo_wr_vld) begin
            out_state_d = FREE;
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            out_state_q <= FREE;
            cnt_q       <= '0;
            pack_q      <= '0;
            out_q       <= '0;
        end else begin
            out_state_q <= out_state_d;
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            out_q       <= out_d;
        end
    end

`ifdef IPML_PACK_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (din_vld && !din_rdy && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
